bus_arbiter_n: RTL

Parametrised N-master arbiter and slave-select decoder for the system bus; successor to the fixed two-master arbitration used in the bus top. Accepts per-master `approval_request` plus a target slave index, grants exactly one master at a time under fixed-priority or round-robin policy, and drives a one-hot slave enable for the latched target. It adds a grant-hold timeout and decode-error rejection, which the two-master version lacks.

---
 rtl/bus_arbiter_n.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: N-master system bus arbiter with slave-select decode.
// Grants one master at a time under fixed-priority or round-robin policy,
// drives a one-hot slave enable for the latched target, rejects requests to
// non-existent slaves and forcibly releases masters that overstay TIMEOUT.
module bus_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SSW         = 2,
  parameter int MODE        = 1,
  parameter int TIMEOUT     = 4095
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_MASTERS-1:0]                                 approval_request,
  input  logic [NUM_MASTERS*SSW-1:0]                             slave_select_in,
  output logic [NUM_MASTERS-1:0]                                 approval_grant,
  output logic [$clog2(NUM_MASTERS > 1 ? NUM_MASTERS : 2)-1:0]   grant_id,
  output logic [NUM_SLAVES-1:0]                                  slave_enable,
  output logic                                                   bus_busy,
  output logic                                                   timeout_pulse,
  output logic                                                   decode_error
);

  localparam int GW = $clog2(NUM_MASTERS > 1 ? NUM_MASTERS : 2);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [11:0]   CNT_MAX     = 12'd4095;
  localparam logic [11:0]   TIMEOUT_VAL = 12'(TIMEOUT);
  localparam logic [GW-1:0] PTR_RESET   = GW'(NUM_MASTERS - 1);

  logic [1:0]             state;
  logic [NUM_MASTERS-1:0] mask;
  logic [11:0]            hold_count;
  logic [GW-1:0]          rr_pointer;

  logic [NUM_MASTERS-1:0] eligible;
  logic                   winner_found;
  logic [GW-1:0]          winner;
  logic [SSW-1:0]         winner_target;
  int                     rank;
  int                     best_rank;

  logic                   target_valid;
  logic [NUM_SLAVES-1:0]  target_onehot;
  logic [NUM_MASTERS-1:0] winner_onehot;
  logic                   owner_request;
  logic                   timed_out;

  // Pick the winner among unmasked requesters: lowest rank wins, where rank is
  // the master index (fixed priority) or the distance past the RR pointer.
  always_comb begin
    eligible      = approval_request & ~mask;
    winner_found  = 1'b0;
    winner        = '0;
    winner_target = '0;
    best_rank     = NUM_MASTERS;
    rank          = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (MODE == 0) begin
        rank = i;
      end else begin
        rank = i - int'(rr_pointer) - 1;
        if (rank < 0) rank = rank + NUM_MASTERS;
      end
      if (eligible[i] && (rank < best_rank)) begin
        best_rank     = rank;
        winner_found  = 1'b1;
        winner        = GW'(i);
        winner_target = slave_select_in[i*SSW +: SSW];
      end
    end
  end

  // Decode the winner's target and identity, and the release conditions.
  always_comb begin
    target_valid  = (int'(winner_target) < NUM_SLAVES);
    target_onehot = '0;
    winner_onehot = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      target_onehot[s] = (int'(winner_target) == s);
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      winner_onehot[i] = winner_found && (int'(winner) == i);
    end
    owner_request = |(approval_request & approval_grant);
    timed_out     = (TIMEOUT != 0) && (hold_count == TIMEOUT_VAL);
  end

  // Arbitration FSM with registered grant, enable and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      mask           <= '0;
      hold_count     <= '0;
      rr_pointer     <= PTR_RESET;
      approval_grant <= '0;
      slave_enable   <= '0;
      grant_id       <= '0;
      bus_busy       <= 1'b0;
      timeout_pulse  <= 1'b0;
      decode_error   <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      decode_error  <= 1'b0;
      mask          <= mask & approval_request;
      case (state)
        IDLE: begin
          if (winner_found) begin
            if (target_valid) begin
              state          <= GRANT;
              approval_grant <= winner_onehot;
              slave_enable   <= target_onehot;
              grant_id       <= winner;
              bus_busy       <= 1'b1;
            end else begin
              decode_error <= 1'b1;
              mask         <= (mask & approval_request) | winner_onehot;
            end
          end
        end
        GRANT: begin
          state      <= HOLD;
          hold_count <= 12'd1;
        end
        HOLD: begin
          if (!owner_request || timed_out) begin
            state          <= RELEASE;
            approval_grant <= '0;
            slave_enable   <= '0;
            grant_id       <= '0;
            bus_busy       <= 1'b0;
            rr_pointer     <= grant_id;
            if (owner_request) begin
              timeout_pulse <= 1'b1;
              mask          <= (mask & approval_request) | approval_grant;
            end
          end else if (hold_count != CNT_MAX) begin
            hold_count <= hold_count + 12'd1;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
